mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates a single-ported, variable-latency memory between the instruction-fetch port and the data port of the pipelined MIPS core. Data accesses are the loads and stores the main decoder marks with MemToRegM and MemWriteM. The block owns a three-state grant FSM, latches the winning request onto a req/ack memory handshake, and returns read data with a one-cycle valid pulse. It also generates the fetch and memory-stage stall signals consumed by the hazard logic.

## Interface

- AW, 32, address width (bytes)
- DW, 32, data width; byte mask width is DW/8

- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; level, held until if_valid
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched instruction; valid when if_valid=1
- if_valid  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; level, held until d_valid
- d_we  in  1  1=store, 0=load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data, already lane-aligned
- d_wmask  in  DW/8  store byte enables (SB/SH/SW)
- d_rdata  out  DW  load data; valid when d_valid=1
- d_valid  out  1  one-cycle completion pulse for data (loads and stores)
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  write strobe qualifier
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_wmask  out  DW/8  byte enables; 0 for every read
- mem_ack  in  1  one-cycle completion from memory; mem_rdata valid same cycle
- mem_rdata  in  DW  memory read data
- stall_f  out  1  if_req & ~if_valid (combinational)
- stall_m  out  1  d_req & ~d_valid (combinational)

## Operation

- FSM states: IDLE, BUSY, RESP.
- IDLE, no request pending: stay in IDLE and drive mem_req=0.
- IDLE, only one request pending: grant that requester.
- IDLE, both requests pending: grant the requester not granted last.
  - last_grant resets to IF, so the first tie goes to data.
- On grant, register addr, we, wdata and mask onto the mem_* outputs, set mem_req=1, and go to BUSY.
- Fetch grant fixes mem_we=0 and mem_wmask=0. A data load fixes mem_wmask=0.
- BUSY: hold mem_req and all mem_* outputs stable until mem_ack. mem_ack is ignored in every other state.
- BUSY with mem_ack:
  - Drop mem_req next cycle.
  - For a read, capture mem_rdata into the granted port's rdata register.
  - Set the granted port's valid for next cycle, update last_grant, and go to RESP.
- RESP: the granted valid is 1 for exactly this cycle. Requests are not sampled in RESP. Next state is IDLE.
- Requesters treat valid as consumption. A req still high in the following IDLE cycle is a new request.
- rdata registers hold their value until the next read completion on that port. Stores leave d_rdata unchanged.
- Input changes while BUSY have no effect on the mem_* outputs.

## Timing

- Reset (rst_n=0 at a clk edge) forces:
  - state=IDLE
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0
  - if_valid=0, d_valid=0
  - if_rdata=0, d_rdata=0
  - last_grant=IF
- Reset mid-transaction abandons the access with no valid pulse. A mem_ack arriving after reset is ignored.
- Latency from req sampled in IDLE (cycle 0):
  - mem_req high from cycle 1.
  - Ack at cycle 1+k (k≥0) gives valid at cycle 2+k and IDLE at cycle 3+k.
  - Minimum port occupancy is 3 cycles.
- Back-to-back: a losing requester held high is granted in the IDLE cycle after the winner's RESP.
- Stalls are combinational from req and valid. stall drops in the valid cycle, so the pipeline advances on that edge.
- Ack arriving on the same edge mem_req rises (k=0) is legal.

## Test plan

- Fetch only:
  - Stimulus: if_req=1, if_addr=0x0000_0040. Memory acks 2 cycles after mem_req rises with mem_rdata=0x2408_0005.
  - Required: mem_req high in cycles 1-3, mem_we=0, mem_wmask=0. if_valid pulses in cycle 4 with if_rdata=0x2408_0005. stall_f=1 in cycles 0-3 and 0 in cycle 4.
- Tie after reset:
  - Stimulus: if_req and d_req both rise in the same IDLE cycle.
  - Required: data granted first. Fetch granted in the IDLE cycle after d_valid.
  - Stimulus, continued: repeat the tie.
  - Required: data wins again, because the previous grant was IF.
- Store:
  - Stimulus: d_we=1, d_addr=0x100, d_wdata=0x0000_AB00, d_wmask=0010, immediate ack.
  - Required: mem_we=1, mem_wmask=0010. d_valid pulses 2 cycles after grant. d_rdata unchanged from its prior value.
- Load:
  - Stimulus: d_we=0, mem_rdata=0xDEAD_BEEF, 5-cycle ack latency.
  - Required: mem_wmask=0. d_rdata=0xDEAD_BEEF with d_valid. mem_addr is stable while d_addr toggles during BUSY.
- Reset mid-op:
  - Stimulus: drop rst_n for 1 cycle while BUSY, then deliver mem_ack after reset.
  - Required: all outputs reach reset values, no valid pulse, and the FSM stays IDLE.
- Spurious ack:
  - Stimulus: mem_ack pulses while IDLE.
  - Required: no state change and no valid pulse.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port, memory handshake and stall signals around mem_arbiter.
// The arbiter takes the slave view; the core/memory side takes the master view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_rdata;
  logic            if_valid;
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_wmask;
  logic [DW-1:0]   d_rdata;
  logic            d_valid;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;
  logic            stall_f;
  logic            stall_m;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_ack, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
           mem_wmask, stall_f, stall_m
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_ack, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
           mem_wmask, stall_f, stall_m
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one variable-latency req/ack memory between instruction fetch and data access,
// alternating grants on ties and returning read data with a one-cycle valid pulse.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last_d;
  logic            gnt_d;
  logic            start;
  logic            done;
  logic            pick_d;
  logic [AW-1:0]   pick_addr;
  logic            pick_we;
  logic [DW-1:0]   pick_wdata;
  logic [DW/8-1:0] pick_wmask;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.if_req || bus.d_req) state_nxt = BUSY;
      BUSY:    if (bus.mem_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant decision: on a tie the port that did not win last time goes first.
  always_comb begin
    start      = 1'b0;
    done       = 1'b0;
    pick_d     = 1'b0;
    pick_addr  = bus.if_addr;
    pick_we    = 1'b0;
    pick_wdata = '0;
    pick_wmask = '0;
    if (state == IDLE && (bus.if_req || bus.d_req)) begin
      start  = 1'b1;
      pick_d = bus.d_req && (!bus.if_req || !last_d);
      if (pick_d) begin
        pick_addr  = bus.d_addr;
        pick_we    = bus.d_we;
        pick_wdata = bus.d_wdata;
        pick_wmask = bus.d_we ? bus.d_wmask : '0;
      end
    end
    if (state == BUSY && bus.mem_ack) done = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wmask <= '0;
      bus.if_valid  <= 1'b0;
      bus.d_valid   <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
      last_d        <= 1'b0;
      gnt_d         <= 1'b0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;
      if (start) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= pick_we;
        bus.mem_addr  <= pick_addr;
        bus.mem_wdata <= pick_wdata;
        bus.mem_wmask <= pick_wmask;
        gnt_d         <= pick_d;
      end
      if (done) begin
        bus.mem_req <= 1'b0;
        last_d      <= gnt_d;
        if (gnt_d) begin
          bus.d_valid <= 1'b1;
          if (!bus.mem_we) bus.d_rdata <= bus.mem_rdata;
        end else begin
          bus.if_valid <= 1'b1;
          bus.if_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.stall_f = bus.if_req & ~bus.if_valid;
  assign bus.stall_m = bus.d_req & ~bus.d_valid;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: directed timing scenarios followed by randomized
// concurrent fetch/data traffic against a word-addressed reference memory.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus();
  mem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  logic [31:0] q_if[$];
  logic [31:0] q_d[$];
  logic [31:0] ref_mem[int unsigned];
  logic [31:0] mem_store[int unsigned];
  logic [31:0] ref_last_d = '0;
  bit resp_en = 1'b1;
  bit lat_rand = 1'b0;
  int lat_fixed = 0;

  function automatic logic [31:0] init_word(input logic [31:0] key);
    return (key * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    int unsigned key = a >> 2;
    return ref_mem.exists(key) ? ref_mem[key] : init_word(key);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue_fetch(input logic [31:0] a);
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    q_if.push_back(ref_read(a));
  endtask

  task automatic issue_data(input bit we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] m);
    logic [31:0] w;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_wmask = m;
    bus.d_req   = 1'b1;
    if (we) begin
      w = ref_read(a);
      for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = wd[8*b +: 8];
      ref_mem[a >> 2] = w;
    end else begin
      ref_last_d = ref_read(a);
    end
    q_d.push_back(ref_last_d);
  endtask

  // Waits for the port's valid at a negedge, then withdraws that port's request.
  task automatic wait_valid(input bit is_d, input string name, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (is_d ? bus.d_valid : bus.if_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk({name, "_timeout"}, 32'd0, 32'd1);
    if (is_d) bus.d_req = 1'b0;
    else      bus.if_req = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_mem_req"},   32'(bus.mem_req),   32'd0);
    chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    chk({tag, "_mem_addr"},  bus.mem_addr,       32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
    chk({tag, "_mem_wmask"}, 32'(bus.mem_wmask), 32'd0);
    chk({tag, "_if_valid"},  32'(bus.if_valid),  32'd0);
    chk({tag, "_d_valid"},   32'(bus.d_valid),   32'd0);
    chk({tag, "_if_rdata"},  bus.if_rdata,       32'd0);
    chk({tag, "_d_rdata"},   bus.d_rdata,        32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every valid pulse pops the oldest expectation for that port.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus.if_valid) begin
        if (q_if.size() == 0) chk("if_valid_unexpected", 32'd1, 32'd0);
        else chk("if_rdata", bus.if_rdata, q_if.pop_front());
      end
      if (bus.d_valid) begin
        if (q_d.size() == 0) chk("d_valid_unexpected", 32'd1, 32'd0);
        else chk("d_rdata", bus.d_rdata, q_d.pop_front());
      end
    end
  end

  // Memory model: acks each request after a chosen latency and checks bus stability.
  initial begin
    bit active = 1'b0;
    int cnt = 0;
    logic [31:0] r_addr, r_wdata, w;
    logic r_we;
    logic [3:0] r_wmask;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!resp_en) begin
        active = 1'b0;
      end else begin
        bus.mem_ack = 1'b0;
        if (!bus.mem_req) begin
          active = 1'b0;
        end else begin
          if (!active) begin
            active  = 1'b1;
            cnt     = lat_rand ? int'($urandom_range(0, 4)) : lat_fixed;
            r_addr  = bus.mem_addr;
            r_we    = bus.mem_we;
            r_wdata = bus.mem_wdata;
            r_wmask = bus.mem_wmask;
            if (!r_we) chk("mem_wmask_read_zero", 32'(bus.mem_wmask), 32'd0);
          end else begin
            chk("mem_addr_stable", bus.mem_addr, r_addr);
            chk("mem_ctl_stable", {27'd0, bus.mem_we, bus.mem_wmask}, {27'd0, r_we, r_wmask});
            chk("mem_wdata_stable", bus.mem_wdata, r_wdata);
          end
          if (cnt == 0) begin
            bus.mem_ack = 1'b1;
            w = mem_store.exists(r_addr >> 2) ? mem_store[r_addr >> 2] : init_word(r_addr >> 2);
            if (r_we) begin
              for (int b = 0; b < 4; b++) if (r_wmask[b]) w[8*b +: 8] = r_wdata[8*b +: 8];
              mem_store[r_addr >> 2] = w;
              bus.mem_rdata = $urandom;
            end else begin
              bus.mem_rdata = w;
            end
            active = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  task automatic tie_test(input logic [31:0] fa, input logic [31:0] da, input string tag);
    int at;
    lat_fixed = 1;
    @(posedge clk);
    #1;
    base = cyc;
    issue_fetch(fa);
    issue_data(1'b0, da, 32'h0, 4'hF);
    @(negedge clk);
    chk({tag, "_req_c0"}, 32'(bus.mem_req), 32'd0);
    chk({tag, "_stall_f_c0"}, 32'(bus.stall_f), 32'd1);
    chk({tag, "_stall_m_c0"}, 32'(bus.stall_m), 32'd1);
    @(negedge clk);
    chk({tag, "_data_first"}, bus.mem_addr, da);
    wait_valid(1'b1, {tag, "_d"}, at);
    chk({tag, "_d_valid_cycle"}, 32'(at - base), 32'd3);
    @(negedge clk);
    chk({tag, "_idle_gap"}, 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    chk({tag, "_fetch_second_req"}, 32'(bus.mem_req), 32'd1);
    chk({tag, "_fetch_second_addr"}, bus.mem_addr, fa);
    wait_valid(1'b0, {tag, "_f"}, at);
    chk({tag, "_if_valid_cycle"}, 32'(at - base), 32'd7);
  endtask

  initial begin
    int at;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.d_wmask = '0;
    ref_mem[32'h40 >> 2]  = 32'h2408_0005;
    mem_store[32'h40 >> 2] = 32'h2408_0005;
    ref_mem[32'h104 >> 2]  = 32'hDEAD_BEEF;
    mem_store[32'h104 >> 2] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    tie_test(32'h80, 32'h1010, "tie1");
    tie_test(32'h84, 32'h1014, "tie2");

    // Fetch only, ack two cycles after mem_req rises
    lat_fixed = 2;
    @(posedge clk);
    #1;
    base = cyc;
    issue_fetch(32'h40);
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("fetch_mem_req_c%0d", c), 32'(bus.mem_req), 32'((c >= 1 && c <= 3) ? 1 : 0));
      chk($sformatf("fetch_stall_f_c%0d", c), 32'(bus.stall_f), 32'((c <= 3) ? 1 : 0));
      chk($sformatf("fetch_if_valid_c%0d", c), 32'(bus.if_valid), 32'((c == 4) ? 1 : 0));
      if (c == 1) begin
        chk("fetch_mem_addr", bus.mem_addr, 32'h40);
        chk("fetch_mem_we", 32'(bus.mem_we), 32'd0);
        chk("fetch_mem_wmask", 32'(bus.mem_wmask), 32'd0);
      end
      if (c == 4) begin
        chk("fetch_if_rdata", bus.if_rdata, 32'h2408_0005);
        bus.if_req = 1'b0;
      end
    end

    // Store with immediate ack
    lat_fixed = 0;
    @(posedge clk);
    #1;
    base = cyc;
    issue_data(1'b1, 32'h100, 32'h0000_AB00, 4'b0010);
    @(negedge clk);
    @(negedge clk);
    chk("store_mem_req", 32'(bus.mem_req), 32'd1);
    chk("store_mem_we", 32'(bus.mem_we), 32'd1);
    chk("store_mem_wmask", 32'(bus.mem_wmask), 32'h2);
    chk("store_mem_wdata", bus.mem_wdata, 32'h0000_AB00);
    chk("store_mem_addr", bus.mem_addr, 32'h100);
    wait_valid(1'b1, "store", at);
    chk("store_d_valid_cycle", 32'(at - base), 32'd2);
    chk("store_d_rdata_kept", bus.d_rdata, ref_last_d);

    // Load with 5-cycle ack latency while d_addr is scrambled
    lat_fixed = 5;
    @(posedge clk);
    #1;
    base = cyc;
    issue_data(1'b0, 32'h104, 32'h5555_5555, 4'hF);
    @(negedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("load_mem_req", 32'(bus.mem_req), 32'd1);
      chk("load_mem_addr_hold", bus.mem_addr, 32'h104);
      chk("load_mem_wmask", 32'(bus.mem_wmask), 32'd0);
      bus.d_addr  = $urandom;
      bus.d_wdata = $urandom;
    end
    wait_valid(1'b1, "load", at);
    chk("load_d_valid_cycle", 32'(at - base), 32'd7);
    chk("load_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);

    // Spurious ack while idle
    resp_en = 1'b0;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("spurious_mem_req", 32'(bus.mem_req), 32'd0);
      chk("spurious_valids", {30'd0, bus.if_valid, bus.d_valid}, 32'd0);
      chk("spurious_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    end

    // Reset while BUSY, then a late ack
    @(posedge clk);
    #1;
    issue_data(1'b0, 32'h108, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_busy_req", 32'(bus.mem_req), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.d_req = 1'b0;
    q_d.delete();
    ref_last_d = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk_reset_state("rstmid");
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rstmid_idle_req", 32'(bus.mem_req), 32'd0);
      chk("rstmid_no_valid", {30'd0, bus.if_valid, bus.d_valid}, 32'd0);
    end

    // Randomized concurrent traffic
    resp_en = 1'b1;
    lat_rand = 1'b1;
    fork
      begin
        int at_f;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          issue_fetch({20'd0, 4'd0, 6'($urandom_range(0, 63)), 2'b00});
          wait_valid(1'b0, "rand_fetch", at_f);
        end
      end
      begin
        int at_d;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          issue_data(1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 15) * 4),
                     $urandom, 4'($urandom_range(0, 15)));
          wait_valid(1'b1, "rand_data", at_d);
        end
      end
    join
    repeat (4) @(negedge clk);
    chk("q_if_drained", 32'(q_if.size()), 32'd0);
    chk("q_d_drained", 32'(q_d.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
